// File: rtl/lvds_link_ctrl.sv
// Panel sequencer and 7:1 serializer word formatter for a 6-lane video link.
// Runs the power/link/backlight sequence, generates video timing, pulls RGB
// pixels over ready/valid and packs them with sync and the lane-5 clock
// pattern into the 42-bit word the serializer shifts out each pclk.
module lvds_link_ctrl #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 48,
  parameter int unsigned H_BP     = 40,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 13,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned T_PWR    = 1000000,
  parameter int unsigned T_BL     = 2000000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_rdy,
  output logic [41:0] din,
  output logic        ser_rst,
  output logic        panel_pwr,
  output logic        bl_en,
  output logic        frame_start,
  output logic        underflow,
  output logic [2:0]  state
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StPwrUp   = 3'd1,
    StLinkUp  = 3'd2,
    StRun     = 3'd3,
    StBlDown  = 3'd4,
    StPwrDown = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [41:0]   din_q, din_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;
  logic          run_q, run_d, enter_link;
  logic          de, hs, vs;
  logic [7:0]    r, g, b;
  logic [6:0]    lane [6];

  function automatic logic is_run(input state_e s);
    return (s == StLinkUp) || (s == StRun) || (s == StBlDown);
  endfunction

  assign run_q      = is_run(state_q);
  assign run_d      = is_run(state_d);
  assign enter_link = (state_d == StLinkUp) && (state_q != StLinkUp);

  // State and delay-counter register
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the delay counter restarts on every state change
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff:     if (en) state_d = StPwrUp;
      StPwrUp:   if (!en) state_d = StPwrDown;
                 else if (cnt_q == T_PWR - 1) state_d = StLinkUp;
      StLinkUp:  if (!en) state_d = StBlDown;
                 else if (cnt_q == T_BL - 1) state_d = StRun;
      StRun:     if (!en) state_d = StBlDown;
      StBlDown:  if (cnt_q == T_BL - 1) state_d = StPwrDown;
      StPwrDown: if (cnt_q == T_PWR - 1) state_d = StOff;
      default:   state_d = StOff;
    endcase
    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end

  // Control outputs decoded from the state register
  always_comb begin
    state     = state_q;
    panel_pwr = (state_q != StOff);
    bl_en     = (state_q == StRun);
    ser_rst   = !run_q;
    pix_rdy   = de;
  end

  // Timing decode, pixel capture and lane packing
  always_comb begin
    de = run_q && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    // A missing pixel during active video goes out as black, never stalls
    {r, g, b} = (de && pix_valid) ? pix_data : 24'd0;

    // Each lane vector is written slot 6 .. slot 0 (slot 0 shifts out first)
    lane[0] = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
    lane[1] = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
    lane[2] = {b[2], b[3], b[4], b[5], hs, vs, de};
    lane[3] = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    lane[4] = 7'b0000000;
    lane[5] = 7'b1100011;

    din_d = '0;
    if (run_q && run_d) begin
      for (int k = 0; k < 7; k++) begin
        for (int l = 0; l < 6; l++) begin
          din_d[6*k+l] = lane[l][k];
        end
      end
    end

    fs_d = run_q && run_d && (h_q == '0) && (v_q == '0);

    uf_d = uf_q;
    if (enter_link)            uf_d = 1'b0;
    else if (de && !pix_valid) uf_d = 1'b1;

    h_d = h_q;
    v_d = v_q;
    if (!run_d || enter_link) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge pclk) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      din_q <= '0;
      fs_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      din_q <= din_d;
      fs_q  <= fs_d;
      uf_q  <= uf_d;
    end
  end

  assign din         = din_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Directed bench for lvds_link_ctrl with a tiny 8x5 raster and short delays.
module tb_lvds_link_ctrl;

  logic        pclk = 1'b0;
  logic        reset;
  logic        en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_rdy;
  logic [41:0] din;
  logic        ser_rst;
  logic        panel_pwr;
  logic        bl_en;
  logic        frame_start;
  logic        underflow;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-packed words for pix_data = 24'hA5C33C
  localparam logic [41:0] PIX_WORD = 42'h27B0D300865; // DE=1, pixel A5C33C
  localparam logic [41:0] UF_WORD  = 42'h20800000824; // DE=1, black pixel
  localparam logic [41:0] BLANK    = 42'h20800000820; // clock pattern only
  localparam logic [41:0] HS_BIT   = 42'h00000004000; // lane 2 slot 2
  localparam logic [41:0] VS_BIT   = 42'h00000000100; // lane 2 slot 1

  lvds_link_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .T_PWR(5), .T_BL(3)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .en         (en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_rdy    (pix_rdy),
    .din        (din),
    .ser_rst    (ser_rst),
    .panel_pwr  (panel_pwr),
    .bl_en      (bl_en),
    .frame_start(frame_start),
    .underflow  (underflow),
    .state      (state)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          h_e, v_e;
    logic        rdy_e, fs_e, uf_e, drop;
    logic [41:0] din_e;

    reset = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_data = 24'hA5C33C;
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk("rst_ser_rst", 64'(ser_rst), 64'd1);
    chk("rst_panel_pwr", 64'(panel_pwr), 64'd0);
    chk("rst_bl_en", 64'(bl_en), 64'd0);
    chk("rst_pix_rdy", 64'(pix_rdy), 64'd0);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);

    // Power-up: five PWR_UP cycles, panel_pwr one cycle after en
    reset = 1'b0; en = 1'b1; pix_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("pwrup_state", 64'(state), 64'd1);
      chk("pwrup_panel_pwr", 64'(panel_pwr), 64'd1);
      chk("pwrup_ser_rst", 64'(ser_rst), 64'd1);
      chk("pwrup_din", 64'(din), 64'd0);
      if (i < 4) tick();
    end
    tick();

    // Link start and two frames of raster, one dropped pixel in frame 2
    h_e = 0; v_e = 0; din_e = '0; fs_e = 1'b0; uf_e = 1'b0;
    for (int c = 0; c < 96; c++) begin
      rdy_e = (h_e < 4) && (v_e < 2);
      chk("run_state", 64'(state), (c < 3) ? 64'd2 : 64'd3);
      chk("run_bl_en", 64'(bl_en), (c < 3) ? 64'd0 : 64'd1);
      chk("run_ser_rst", 64'(ser_rst), 64'd0);
      chk("run_pix_rdy", 64'(pix_rdy), 64'(rdy_e));
      chk("run_din", 64'(din), 64'(din_e));
      chk("run_frame_start", 64'(frame_start), 64'(fs_e));
      chk("run_underflow", 64'(underflow), 64'(uf_e));
      drop = (c == 49);
      pix_valid = !drop;
      if (rdy_e)   din_e = drop ? UF_WORD : PIX_WORD;
      else         din_e = BLANK | ((h_e == 5 || h_e == 6) ? HS_BIT : 42'd0)
                                 | ((v_e == 3) ? VS_BIT : 42'd0);
      fs_e = (h_e == 0) && (v_e == 0);
      if (drop) uf_e = 1'b1;
      if (h_e == 7) begin
        h_e = 0;
        v_e = (v_e == 4) ? 0 : v_e + 1;
      end else begin
        h_e = h_e + 1;
      end
      tick();
      pix_valid = 1'b1;
    end

    // Power-down from RUN
    en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bldown_state", 64'(state), 64'd4);
      chk("bldown_bl_en", 64'(bl_en), 64'd0);
      chk("bldown_ser_rst", 64'(ser_rst), 64'd0);
      chk("bldown_clk_lane", 64'(din[5]), 64'd1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("pwrdn_state", 64'(state), 64'd5);
      chk("pwrdn_din", 64'(din), 64'd0);
      chk("pwrdn_ser_rst", 64'(ser_rst), 64'd1);
      chk("pwrdn_panel_pwr", 64'(panel_pwr), 64'd1);
      chk("pwrdn_pix_rdy", 64'(pix_rdy), 64'd0);
      tick();
    end
    chk("off_state", 64'(state), 64'd0);
    chk("off_panel_pwr", 64'(panel_pwr), 64'd0);

    // Abort: en drops on the second PWR_UP cycle
    en = 1'b1;
    tick();
    chk("abort_pwrup1", 64'(state), 64'd1);
    tick();
    chk("abort_pwrup2", 64'(state), 64'd1);
    chk("abort_ser_rst_up", 64'(ser_rst), 64'd1);
    en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("abort_pwrdn_state", 64'(state), 64'd5);
      chk("abort_ser_rst", 64'(ser_rst), 64'd1);
      tick();
    end
    chk("abort_off_state", 64'(state), 64'd0);
    chk("abort_off_pwr", 64'(panel_pwr), 64'd0);

    // Reset pulse mid-RUN, with underflow set beforehand
    en = 1'b1; pix_valid = 1'b0;
    repeat (9) tick();
    chk("rr_state", 64'(state), 64'd3);
    chk("rr_bl_en", 64'(bl_en), 64'd1);
    chk("rr_underflow", 64'(underflow), 64'd1);
    reset = 1'b1;
    tick();
    chk("rr_rst_state", 64'(state), 64'd0);
    chk("rr_rst_din", 64'(din), 64'd0);
    chk("rr_rst_ser_rst", 64'(ser_rst), 64'd1);
    chk("rr_rst_panel_pwr", 64'(panel_pwr), 64'd0);
    chk("rr_rst_bl_en", 64'(bl_en), 64'd0);
    chk("rr_rst_pix_rdy", 64'(pix_rdy), 64'd0);
    chk("rr_rst_frame_start", 64'(frame_start), 64'd0);
    chk("rr_rst_underflow", 64'(underflow), 64'd0);
    reset = 1'b0; en = 1'b0;
    tick();
    chk("rr_after_state", 64'(state), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
